// File: rtl/fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fan_ctrl_pkg
// Shared types and default constants for the fan-control tach receive path.
//   tach_state_t          : measurement FSM state (IDLE, COUNT)
//   TACH_*_DEF            : default parameter values for fan_tach_monitor
// No ports (package).
// -----------------------------------------------------------------------------
package fan_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } tach_state_t;

  localparam int unsigned TACH_GATE_CYCLES_DEF  = 100_000_000; // 1 s at 100 MHz
  localparam int unsigned TACH_FILT_CYCLES_DEF  = 8;
  localparam int unsigned TACH_STALL_CYCLES_DEF = 50_000_000;  // 0.5 s at 100 MHz
  localparam int unsigned TACH_CNT_W_DEF        = 16;

endpackage : fan_ctrl_pkg

// File: rtl/tach_glitch_filter.sv
// -----------------------------------------------------------------------------
// tach_glitch_filter
// Two-flop synchronizer, run-length glitch filter and registered rising-edge
// pulse for an asynchronous tach input.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   din    : raw asynchronous input
//   level  : filtered level (changes only after FILT_CYCLES consecutive
//            synced samples disagree with the current level)
//   rise   : one-cycle pulse on a filtered 0->1 transition
// Input-to-rise latency is 2 (sync) + FILT_CYCLES (filter) + 1 (edge) cycles.
// -----------------------------------------------------------------------------
module tach_glitch_filter #(
  parameter int unsigned FILT_CYCLES = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned RUN_W = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             rise_q;

  // The run counter only grows while the synced sample disagrees with the
  // accepted level; the sample that would bring it to FILT_CYCLES commits the
  // new level and restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    run_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (run_q == RUN_LAST) begin
        level_d = sync_q[1];
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // NOTE: every flop, synchronizer included, is cleared by the async reset so the block restarts from a known, edge-free state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      run_q       <= '0;
      rise_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      sync_q      <= {sync_q[0], din};
      level_q     <= level_d;
      run_q       <= run_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule : tach_glitch_filter

// File: rtl/fan_tach_monitor.sv
// -----------------------------------------------------------------------------
// fan_tach_monitor
// Fan tachometer receive path: filters the tach return, counts rising edges
// over a GATE_CYCLES window, publishes the count once per window and flags a
// stalled fan after STALL_CYCLES without an edge.
//   clk         : system clock
//   resetn      : asynchronous active-low reset
//   tach_in     : raw tach input (asynchronous)
//   enable      : measurement enable (synchronous)
//   tach_count  : edge count of the last completed window (saturating)
//   count_valid : one-cycle pulse when tach_count updates
//   overflow    : last completed window saturated the count
//   fan_stall   : no edge for STALL_CYCLES while enabled
// Build option FAN_TACH_INVERT_EN: when defined, tach_in is inverted ahead of
// the synchronizer so falling edges of the pin are counted.
// -----------------------------------------------------------------------------
module fan_tach_monitor
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = TACH_GATE_CYCLES_DEF,
  parameter int unsigned FILT_CYCLES  = TACH_FILT_CYCLES_DEF,
  parameter int unsigned STALL_CYCLES = TACH_STALL_CYCLES_DEF,
  parameter int unsigned CNT_W        = TACH_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tach_in,
  input  logic             enable,
  output logic [CNT_W-1:0] tach_count,
  output logic             count_valid,
  output logic             overflow,
  output logic             fan_stall
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned IDLE_W = $clog2(STALL_CYCLES + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] STALL_MAX = IDLE_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic tach_raw;
  logic filt_level;
  logic tach_rise;

`ifdef FAN_TACH_INVERT_EN
  assign tach_raw = ~tach_in;
`else
  assign tach_raw = tach_in;
`endif

  tach_glitch_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filt (
    .clk   (clk),
    .resetn(resetn),
    .din   (tach_raw),
    .level (filt_level),
    .rise  (tach_rise)
  );

  tach_state_t       state_q, state_d;
  logic [GATE_W-1:0] gate_q,  gate_d;
  logic [CNT_W-1:0]  edge_q,  edge_d;
  logic              sat_q,   sat_d;
  logic [IDLE_W-1:0] idle_q,  idle_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q,   ovf_d;
  logic              valid_q, valid_d;

  // Edge count including an edge arriving this cycle, saturating at CNT_MAX.
  logic [CNT_W-1:0] edge_inc;
  logic             sat_next;

  always_comb begin
    edge_inc = edge_q;
    sat_next = sat_q;
    if (tach_rise) begin
      if (edge_q == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_inc = edge_q + 1'b1;
      end
    end
  end

  // Window counters default to zero, so IDLE and the COUNT->IDLE transition
  // both discard any partial window without extra code.
  always_comb begin
    state_d = state_q;
    gate_d  = '0;
    edge_d  = '0;
    sat_d   = 1'b0;
    idle_d  = '0;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = COUNT;
      end

      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          // An edge beats the saturating increment, so an edge landing on the
          // cycle idle_cnt would reach STALL_CYCLES prevents the stall.
          if (tach_rise)                idle_d = '0;
          else if (idle_q == STALL_MAX) idle_d = idle_q;
          else                          idle_d = idle_q + 1'b1;

          if (gate_q == GATE_LAST) begin
            // Terminal cycle: an edge here belongs to the closing window.
            count_d = edge_inc;
            ovf_d   = sat_next;
            valid_d = 1'b1;
          end else begin
            gate_d = gate_q + 1'b1;
            edge_d = edge_inc;
            sat_d  = sat_next;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      idle_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      idle_q  <= idle_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign tach_count  = count_q;
  assign overflow    = ovf_q;
  assign count_valid = valid_q;
  assign fan_stall   = (state_q == COUNT) && (idle_q == STALL_MAX);

endmodule : fan_tach_monitor

// File: tb/tb_fan_tach_monitor.sv
// -----------------------------------------------------------------------------
// tb_fan_tach_monitor
// Scoreboard bench for fan_tach_monitor with GATE_CYCLES=100, FILT_CYCLES=2,
// STALL_CYCLES=300, CNT_W=4. The stimulus process pushes the expected window
// result for each window it shapes; a monitor pops and compares on every
// count_valid. Windows in which the tach pattern changes are pushed as
// wildcards and not scored. When built with FAN_TACH_INVERT_EN the physical
// waveform is inverted so the logical stimulus and expectations are unchanged.
// -----------------------------------------------------------------------------
module tb_fan_tach_monitor;

  localparam int GATE  = 100;
  localparam int FILT  = 2;
  localparam int STALL = 300;
  localparam int CW    = 4;

`ifdef FAN_TACH_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  localparam int M_LOW   = 0;
  localparam int M_HIGH  = 1;
  localparam int M_SQ    = 2;
  localparam int M_SPIKE = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tach_in = INV;
  logic          enable = 1'b0;
  logic [CW-1:0] tach_count;
  logic          count_valid;
  logic          overflow;
  logic          fan_stall;

  int mode = M_LOW;
  int per  = 20;

  typedef struct {
    bit          wild;
    logic [CW-1:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  fan_tach_monitor #(
    .GATE_CYCLES (GATE),
    .FILT_CYCLES (FILT),
    .STALL_CYCLES(STALL),
    .CNT_W       (CW)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .tach_in    (tach_in),
    .enable     (enable),
    .tach_count (tach_count),
    .count_valid(count_valid),
    .overflow   (overflow),
    .fan_stall  (fan_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else             pass_cnt++;
  endtask

  task automatic push(input bit wild, input logic [CW-1:0] cnt, input logic ovf);
    exp_t e;
    e.wild = wild;
    e.cnt  = cnt;
    e.ovf  = ovf;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  task automatic wait_valid(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (count_valid) seen = 1'b1;
    end
    check("valid_arrives", seen, 1);
  endtask

  // Tach generator: updates 2 time units after each rising edge so the DUT
  // samples a stable level; sole writer of tach_in.
  initial begin
    int   ph;
    int   sp;
    logic lvl;
    ph = 0;
    sp = 0;
    forever begin
      @(posedge clk);
      #2;
      lvl = 1'b0;
      case (mode)
        M_HIGH:  lvl = 1'b1;
        M_SQ: begin
          lvl = (ph < per / 2);
          ph  = (ph + 1) % per;
        end
        M_SPIKE: begin
          lvl = (sp == 0);
          sp  = (sp + 1) % 7;
        end
        default: lvl = 1'b0;
      endcase
      if (mode != M_SQ) ph = 0;
      tach_in = lvl ^ INV;
    end
  end

  // Monitor: scores every count_valid pulse against the scoreboard, plus the
  // pulse width and the window-to-window spacing.
  initial begin
    int   cyc;
    int   last;
    logic prev_v;
    exp_t e;
    cyc    = 0;
    last   = -1;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn || !enable) last = -1;
      if (resetn && count_valid) begin
        check("valid_width", prev_v, 0);
        if (last >= 0) check("valid_period", cyc - last, GATE);
        last = cyc;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (!e.wild) begin
            check("tach_count", tach_count, e.cnt);
            check("overflow", overflow, e.ovf);
          end
        end
      end
      prev_v = count_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tach_count", tach_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_fan_stall", fan_stall, 0);
    resetn = 1'b1;

    // Clean rate: period 20 running before enable gives exactly 5 per window
    mode = M_SQ;
    per  = 20;
    repeat (40) @(negedge clk);
    check("idle_no_valid", count_valid, 0);
    enable = 1'b1;
    push(0, 5, 0);
    push(0, 5, 0);
    push(0, 5, 0);
    wait_drain(400);
    check("clean_fan_stall", fan_stall, 0);

    // Glitch rejection: 1-cycle spikes never survive a 2-sample filter
    mode = M_SPIKE;
    push(1, 0, 0);
    push(0, 0, 0);
    push(0, 0, 0);
    wait_drain(400);

    // Saturation: 25 edges per window clamp at 15 with overflow
    mode = M_SQ;
    per  = 4;
    push(1, 0, 0);
    push(0, 15, 1);
    wait_drain(300);
    per = 20;
    push(1, 0, 0);
    push(0, 5, 0);
    wait_drain(300);

    // Stall: one edge, then quiet. HIGH set before edge e+1 reaches the
    // pulse at e+6; it is consumed at e+7 and the stall shows at e+307.
    mode = M_LOW;
    repeat (40) @(negedge clk);
    mode = M_HIGH;
    repeat (6) @(negedge clk);
    mode = M_LOW;
    repeat (300) @(negedge clk);
    check("stall_not_yet", fan_stall, 0);
    @(negedge clk);
    check("stall_assert", fan_stall, 1);

    // Single new edge: stall still high during its pulse, low the cycle after
    mode = M_HIGH;
    repeat (6) @(negedge clk);
    check("stall_during_pulse", fan_stall, 1);
    mode = M_LOW;
    @(negedge clk);
    check("stall_cleared", fan_stall, 0);

    // Edge consumed exactly when idle_cnt would hit 300: no stall
    repeat (293) @(negedge clk);
    mode = M_HIGH;
    repeat (6) @(negedge clk);
    mode = M_LOW;
    @(negedge clk);
    check("stall_tie_edge_wins", fan_stall, 0);
    @(negedge clk);
    check("stall_tie_next", fan_stall, 0);
    repeat (300) @(negedge clk);
    check("stall_reassert", fan_stall, 1);
    enable = 1'b0;
    @(negedge clk);
    check("stall_disable", fan_stall, 0);
    repeat (2) @(negedge clk);

    // Enable dropped at gate_cnt = 50: partial window discarded
    enable = 1'b1;
    mode   = M_SQ;
    per    = 20;
    push(1, 0, 0);
    push(0, 5, 0);
    wait_valid(300);
    wait_valid(300);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (count_valid) n++;
    end
    check("disabled_no_valid", n, 0);
    check("disabled_tach_count", tach_count, 5);
    check("disabled_overflow", overflow, 0);
    check("disabled_fan_stall", fan_stall, 0);

    // Asynchronous reset mid-window
    mode   = M_LOW;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_tach_count", tach_count, 0);
    check("async_rst_overflow", overflow, 0);
    check("async_rst_count_valid", count_valid, 0);
    check("async_rst_fan_stall", fan_stall, 0);
    repeat (3) @(negedge clk);

    // Release with enable high: one IDLE cycle, then a fresh 100-cycle window
    // closing on the 101st edge after release, holding 5 edges.
    resetn = 1'b1;
    mode   = M_SQ;
    per    = 20;
    push(0, 5, 0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (count_valid) seen = 1'b1;
    end
    check("rst_first_valid_cycle", n, GATE + 1);
    wait_drain(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_fan_tach_monitor
